spi_byte_tx: RTL

SPI master byte transmitter, directly downstream of the 64-bit frame sequencer.
- Sequencer side: takes the frame-start pulse and the sequencer's byte bus, serialises each byte MSB-first in SPI mode 0 (CPOL=0, CPHA=0), and returns a per-byte done pulse that advances the sequencer to the next byte.
- Frame framing: drives chip-select for the whole frame of BYTES_PER_FRAME bytes.

---
 rtl/spi_byte_tx_if.sv | 21 ++
 rtl/spi_byte_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/spi_byte_tx_if.sv
// Sequencer-to-transmitter bundle: frame start, byte bus, done/busy status and the SPI pins.
// master is the sequencer/board side, slave is the transmitter.
interface spi_byte_tx_if;
   logic       spi_start_flag;
   logic [7:0] data_send;
   logic       send8b_done;
   logic       busy;
   logic       spi_cs_n;
   logic       spi_sclk;
   logic       spi_mosi;

   modport master (
      output spi_start_flag, data_send,
      input  send8b_done, busy, spi_cs_n, spi_sclk, spi_mosi
   );

   modport slave (
      input  spi_start_flag, data_send,
      output send8b_done, busy, spi_cs_n, spi_sclk, spi_mosi
   );
endinterface

// File: rtl/spi_byte_tx.sv
// SPI mode-0 master that sends BYTES_PER_FRAME bytes MSB-first per start pulse under one
// chip-select, pulsing send8b_done after each byte so the sequencer can present the next one.
module spi_byte_tx #(
   parameter int CLK_DIV         = 4,
   parameter int BYTES_PER_FRAME = 8,
   parameter int LOAD_DLY        = 4,
   parameter int DONE_HOLD       = 2,
   parameter int CS_HOLD         = 2
) (
   input logic          sys_clk,
   input logic          rst,
   spi_byte_tx_if.slave bus
);

   localparam int HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BC_W    = $clog2(BYTES_PER_FRAME + 1);
   localparam int DLY_MAX = (LOAD_DLY > DONE_HOLD) ?
                            ((LOAD_DLY > CS_HOLD) ? LOAD_DLY : CS_HOLD) :
                            ((DONE_HOLD > CS_HOLD) ? DONE_HOLD : CS_HOLD);
   localparam int DC_W    = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

   localparam logic [HC_W-1:0] HC_LAST   = HC_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BYTES_PER_FRAME);
   localparam logic [DC_W-1:0] LOAD_LAST = DC_W'((LOAD_DLY  > 0) ? LOAD_DLY  - 1 : 0);
   localparam logic [DC_W-1:0] DONE_LAST = DC_W'((DONE_HOLD > 0) ? DONE_HOLD - 1 : 0);
   localparam logic [DC_W-1:0] HOLD_LAST = DC_W'((CS_HOLD   > 0) ? CS_HOLD   - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOAD,
      SHIFT,
      DONE,
      GAP,
      HOLD
   } state_t;

   state_t          state;
   logic [7:0]      shreg;
   logic [HC_W-1:0] hcnt;
   logic [3:0]      tog_cnt;
   logic [BC_W-1:0] byte_cnt;
   logic [DC_W-1:0] dly_cnt;
   logic            done;
   logic            active;
   logic            cs_n;
   logic            sclk;

   // MOSI is the shift register MSB: it changes only on LOAD and falling SCLK edges.
   assign bus.spi_mosi    = shreg[7];
   assign bus.spi_sclk    = sclk;
   assign bus.spi_cs_n    = cs_n;
   assign bus.busy        = active;
   assign bus.send8b_done = done;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         hcnt     <= '0;
         tog_cnt  <= '0;
         byte_cnt <= '0;
         dly_cnt  <= '0;
         done     <= 1'b0;
         active   <= 1'b0;
         cs_n     <= 1'b1;
         sclk     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.spi_start_flag) begin
                  state    <= SETUP;
                  cs_n     <= 1'b0;
                  active   <= 1'b1;
                  byte_cnt <= '0;
                  dly_cnt  <= '0;
               end
            end

            SETUP, GAP: begin
               if (dly_cnt == LOAD_LAST) begin
                  state   <= LOAD;
                  dly_cnt <= '0;
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end

            LOAD: begin
               shreg   <= bus.data_send;
               hcnt    <= '0;
               tog_cnt <= '0;
               state   <= SHIFT;
            end

            SHIFT: begin
               if (hcnt == HC_LAST) begin
                  hcnt    <= '0;
                  sclk    <= ~sclk;
                  tog_cnt <= tog_cnt + 1'b1;
                  // 16th toggle is the 8th falling edge: byte finished, no further shift.
                  if (tog_cnt == 4'd15) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     byte_cnt <= byte_cnt + 1'b1;
                     dly_cnt  <= '0;
                  end else if (sclk) begin
                     shreg <= {shreg[6:0], 1'b0};
                  end
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end

            DONE: begin
               if (dly_cnt == DONE_LAST) begin
                  done    <= 1'b0;
                  dly_cnt <= '0;
                  state   <= (byte_cnt == BC_LAST) ? HOLD : GAP;
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end

            HOLD: begin
               if (dly_cnt == HOLD_LAST) begin
                  state   <= IDLE;
                  cs_n    <= 1'b1;
                  active  <= 1'b0;
                  shreg   <= '0;
                  dly_cnt <= '0;
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
